// File: rtl/ides4_pkg.sv
// Shared constants and types for the ides4_soft 4:1 fabric deserializer.
package ides4_pkg;

  localparam int unsigned DES_W = 4;

  // Training word as seen on q (q[0] = first bit received).
  localparam logic [DES_W-1:0] PATTERN_DEFAULT = 4'b1010;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } align_state_t;

endpackage

// File: rtl/ides4_soft_if.sv
// Serial-in / word-out bundle of ides4_soft. The driver of the serial stream
// and consumer of the words uses master; the deserializer uses slave.
interface ides4_soft_if;
  import ides4_pkg::*;

  logic             d;
  logic             calib;
  logic             align_en;
  logic [DES_W-1:0] q;
  logic             q_valid;
  logic             pclk_o;
  logic             locked;
  logic [1:0]       slip_ofs;
  logic [15:0]      err_cnt;

  modport master (
    output d, calib, align_en,
    input  q, q_valid, pclk_o, locked, slip_ofs, err_cnt
  );

  modport slave (
    input  d, calib, align_en,
    output q, q_valid, pclk_o, locked, slip_ofs, err_cnt
  );

endinterface

// File: rtl/ides4_word_aligner.sv
// Word-boundary hunt FSM for ides4_soft: compares each word against the
// training pattern, requests bitslips while hunting and tracks lock/loss.
module ides4_word_aligner
  import ides4_pkg::*;
#(
  parameter logic [DES_W-1:0] PATTERN      = PATTERN_DEFAULT,
  parameter int unsigned      LOCK_COUNT   = 8,
  parameter int unsigned      LOSS_COUNT   = 4,
  parameter int unsigned      SLIP_HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DES_W-1:0] q,
  input  logic             q_valid,
  input  logic             align_en,
  input  logic             calib,
  input  logic             slip_done,
  output logic             slip_req,
  output logic             locked
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_COUNT);
  localparam logic [3:0] HOLD_N = 4'(SLIP_HOLDOFF);

  align_state_t state, state_n;
  logic [7:0]   match_cnt, match_n;
  logic [7:0]   miss_cnt, miss_n;
  logic [3:0]   hold_cnt, hold_n;
  logic         slipped, slipped_n;
  logic         hit;

  assign hit    = (q == PATTERN);
  assign locked = (state == LOCKED);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      hold_cnt  <= '0;
      slipped   <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      hold_cnt  <= hold_n;
      slipped   <= slipped_n;
    end
  end

  // Next state, counter updates and slip request.
  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    miss_n    = miss_cnt;
    hold_n    = hold_cnt;
    slipped_n = slipped;
    slip_req  = 1'b0;
    if (calib) begin
      // A calib landing on the executing slip is merged into it, so that
      // slip counts as done here rather than waiting for one that never comes.
      match_n   = '0;
      miss_n    = '0;
      hold_n    = '0;
      slipped_n = slip_done;
      state_n   = (slip_done && HOLD_N == 4'd0) ? HUNT : SLIP_WAIT;
    end else begin
      case (state)
        HUNT: begin
          if (q_valid) begin
            if (hit) begin
              if (match_cnt + 8'd1 == LOCK_N) begin
                state_n = LOCKED;
                match_n = '0;
              end else begin
                match_n = match_cnt + 8'd1;
              end
            end else begin
              match_n = '0;
              if (align_en) begin
                slip_req  = 1'b1;
                state_n   = SLIP_WAIT;
                hold_n    = '0;
                slipped_n = 1'b0;
              end
            end
          end
        end
        SLIP_WAIT: begin
          if (!slipped) begin
            if (slip_done) begin
              if (HOLD_N == 4'd0) state_n = HUNT;
              else                slipped_n = 1'b1;
            end
          end else if (q_valid) begin
            if ({1'b0, hold_cnt} + 5'd1 == {1'b0, HOLD_N}) begin
              state_n   = HUNT;
              hold_n    = '0;
              slipped_n = 1'b0;
            end else begin
              hold_n = hold_cnt + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (q_valid) begin
            if (hit) begin
              miss_n = '0;
            end else if (miss_cnt + 8'd1 == LOSS_N) begin
              state_n = HUNT;
              miss_n  = '0;
              match_n = '0;
            end else begin
              miss_n = miss_cnt + 8'd1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: rtl/ides4_soft.sv
// ides4_soft: fabric 4:1 deserializer with divided word clock, bitslip and
// training-pattern lock. Optional error counter enabled by IDES4_ERRCNT_EN.
module ides4_soft
  import ides4_pkg::*;
#(
  parameter logic [DES_W-1:0] PATTERN      = PATTERN_DEFAULT,
  parameter int unsigned      LOCK_COUNT   = 8,
  parameter int unsigned      LOSS_COUNT   = 4,
  parameter int unsigned      SLIP_HOLDOFF = 2
) (
  input  logic         clk,
  input  logic         rst_i,
  ides4_soft_if.slave  bus
);

  // Only the three most recent bits are kept; the fourth is d itself at the
  // capture edge, so the word is identical to a 4-bit shift register's.
  logic [DES_W-2:0] sr;
  logic [1:0]       phase, phase_n;
  logic             slip_pend;
  logic             slip_exec;
  logic [DES_W-1:0] q_r;
  logic             qv_r;
  logic             pclk_r;
  logic [1:0]       ofs_r;
  logic             slip_req;
  logic             locked;

  assign slip_exec = (phase == 2'd3) && slip_pend;
  assign phase_n   = slip_exec ? 2'd3 : phase + 2'd1;

  // Shift register, word phase, bitslip execution and word capture.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sr        <= '0;
      phase     <= '0;
      slip_pend <= 1'b0;
      q_r       <= '0;
      qv_r      <= 1'b0;
      pclk_r    <= 1'b0;
      ofs_r     <= '0;
    end else begin
      sr     <= {bus.d, sr[DES_W-2:1]};
      phase  <= phase_n;
      pclk_r <= ~phase_n[1];
      qv_r   <= 1'b0;
      if (slip_exec) begin
        slip_pend <= 1'b0;
        ofs_r     <= ofs_r + 2'd1;
      end else begin
        slip_pend <= slip_pend | bus.calib | slip_req;
        if (phase == 2'd3) begin
          q_r  <= {bus.d, sr};
          qv_r <= 1'b1;
        end
      end
    end
  end

  ides4_word_aligner #(
    .PATTERN      (PATTERN),
    .LOCK_COUNT   (LOCK_COUNT),
    .LOSS_COUNT   (LOSS_COUNT),
    .SLIP_HOLDOFF (SLIP_HOLDOFF)
  ) u_aligner (
    .clk       (clk),
    .rst       (rst_i),
    .q         (q_r),
    .q_valid   (qv_r),
    .align_en  (bus.align_en),
    .calib     (bus.calib),
    .slip_done (slip_exec),
    .slip_req  (slip_req),
    .locked    (locked)
  );

`ifdef IDES4_ERRCNT_EN
  logic [15:0] err_r;

  // Saturating count of mismatching words seen while locked.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      err_r <= '0;
    end else if (locked && qv_r && (q_r != PATTERN) && (err_r != 16'hFFFF)) begin
      err_r <= err_r + 16'd1;
    end
  end

  assign bus.err_cnt = err_r;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.q        = q_r;
  assign bus.q_valid  = qv_r;
  assign bus.pclk_o   = pclk_r;
  assign bus.locked   = locked;
  assign bus.slip_ofs = ofs_r;

endmodule

// File: tb/tb_ides4_soft.sv
// Directed testbench for ides4_soft: alignment, bitslip, lock/loss, calib,
// merged slips and mid-word reset.
module tb_ides4_soft;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ides4_soft_if bus();

  ides4_soft u_dut (
    .clk   (clk),
    .rst_i (rst),
    .bus   (bus)
  );

`ifdef IDES4_ERRCNT_EN
  localparam logic [31:0] ERR_EXP = 32'd7;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          e;
  int          n_qv;
  logic [3:0]  last_q;
  int          last_rise, n_rise, n5, nbad;
  logic        pclk_prev;
  logic        alt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // One bit per clk; outputs sampled 1 time unit after the rising edge.
  task automatic tick(input logic b);
    bus.d = b;
    @(posedge clk);
    #1;
    e++;
    if (bus.q_valid) begin
      n_qv++;
      last_q = bus.q;
    end
    if (bus.pclk_o && !pclk_prev) begin
      n_rise++;
      if (n_rise >= 3) begin
        if (e - last_rise == 5)      n5++;
        else if (e - last_rise != 4) nbad++;
      end
      last_rise = e;
    end
    pclk_prev = bus.pclk_o;
  endtask

  task automatic alt_bits(input int n);
    for (int i = 0; i < n; i++) begin
      tick(alt);
      alt = ~alt;
    end
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) tick(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.d = 1'b0;
    bus.calib = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0; n_qv = 0; n_rise = 0; n5 = 0; nbad = 0; last_rise = 0;
    pclk_prev = bus.pclk_o;
  endtask

  initial begin
    bus.d = 1'b0;
    bus.calib = 1'b0;
    bus.align_en = 1'b1;
    alt = 1'b0;
    do_reset();

    check_eq("rst_q",        32'(bus.q),        32'h0);
    check_eq("rst_q_valid",  32'(bus.q_valid),  32'h0);
    check_eq("rst_locked",   32'(bus.locked),   32'h0);
    check_eq("rst_slip_ofs", 32'(bus.slip_ofs), 32'h0);
    check_eq("rst_pclk",     32'(bus.pclk_o),   32'h0);
    check_eq("rst_err_cnt",  32'(bus.err_cnt),  32'h0);

    // Aligned stream 0,1,0,1: q = 1010 every four bits, lock after word 8.
    tick(1'b0); tick(1'b1); tick(1'b0);
    check_eq("t1_qv_early", 32'(bus.q_valid), 32'h0);
    tick(1'b1);
    check_eq("t1_qv_first", 32'(bus.q_valid), 32'h1);
    check_eq("t1_q_first",  32'(bus.q),       32'ha);
    for (int i = 0; i < 7; i++) send_word(4'b1010);
    check_eq("t1_unlocked_w8", 32'(bus.locked), 32'h0);
    send_word(4'b1010);
    check_eq("t1_locked",   32'(bus.locked),   32'h1);
    check_eq("t1_n_qv",     32'(n_qv),         32'd9);
    check_eq("t1_slip_ofs", 32'(bus.slip_ofs), 32'h0);
    check_eq("t1_pclk_bad", 32'(nbad),         32'd0);
    check_eq("t1_pclk_5",   32'(n5),           32'd0);

    // Three bad words then a good one keep lock; four bad words drop it.
    for (int i = 0; i < 3; i++) send_word(4'b0000);
    send_word(4'b1010);
    check_eq("t3_hold_lock", 32'(bus.locked), 32'h1);
    for (int i = 0; i < 4; i++) send_word(4'b0000);
    check_eq("t3_lock_4th_qv", 32'(bus.locked), 32'h1);
    send_word(4'b1010);
    check_eq("t3_lost",    32'(bus.locked),  32'h0);
    check_eq("t3_err_cnt", 32'(bus.err_cnt), ERR_EXP);

    // Stream delayed by one bit: one slip, two holdoff words, eight matches.
    do_reset();
    alt = 1'b1;
    alt_bits(4);
    check_eq("t2_q_mis", 32'(bus.q), 32'h5);
    alt_bits(5);
    check_eq("t2_qv_after_slip", 32'(bus.q_valid),  32'h1);
    check_eq("t2_q_after_slip",  32'(bus.q),        32'ha);
    check_eq("t2_slip_ofs",      32'(bus.slip_ofs), 32'h1);
    alt_bits(36);
    check_eq("t2_unlocked", 32'(bus.locked), 32'h0);
    alt_bits(1);
    check_eq("t2_locked",   32'(bus.locked), 32'h1);
    check_eq("t2_n_qv",     32'(n_qv),       32'd11);
    check_eq("t2_pclk_5",   32'(n5),         32'd1);
    check_eq("t2_pclk_bad", 32'(nbad),       32'd0);

    // align_en=0: misaligned words never slip; one calib realigns.
    do_reset();
    bus.align_en = 1'b0;
    alt = 1'b1;
    alt_bits(25);
    check_eq("t4_no_slip", 32'(bus.slip_ofs), 32'h0);
    check_eq("t4_no_lock", 32'(bus.locked),   32'h0);
    check_eq("t4_last_q",  32'(last_q),       32'h5);
    check_eq("t4_n_qv",    32'(n_qv),         32'd6);
    bus.calib = 1'b1;
    alt_bits(1);
    bus.calib = 1'b0;
    alt_bits(3);
    check_eq("t4_q_realign", 32'(bus.q),        32'ha);
    check_eq("t4_slip_ofs",  32'(bus.slip_ofs), 32'h1);
    alt_bits(36);
    check_eq("t4_unlocked", 32'(bus.locked), 32'h0);
    alt_bits(1);
    check_eq("t4_locked",   32'(bus.locked), 32'h1);
    check_eq("t4_pclk_hi",  32'(bus.pclk_o), 32'h1);

    // Reset mid-word while locked.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_q",        32'(bus.q),        32'h0);
    check_eq("t6_q_valid",  32'(bus.q_valid),  32'h0);
    check_eq("t6_locked",   32'(bus.locked),   32'h0);
    check_eq("t6_slip_ofs", 32'(bus.slip_ofs), 32'h0);
    check_eq("t6_pclk",     32'(bus.pclk_o),   32'h0);
    check_eq("t6_err_cnt",  32'(bus.err_cnt),  32'h0);
    rst = 1'b0;

    // calib coincident with the internal slip request: a single slip.
    do_reset();
    bus.align_en = 1'b1;
    alt = 1'b1;
    alt_bits(4);
    bus.calib = 1'b1;
    alt_bits(1);
    bus.calib = 1'b0;
    alt_bits(4);
    check_eq("t5_slip_ofs", 32'(bus.slip_ofs), 32'h1);
    check_eq("t5_q",        32'(bus.q),        32'ha);
    alt_bits(11);
    check_eq("t5_slip_ofs_hold", 32'(bus.slip_ofs), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
